// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-port SPI flash arbiter.
package flash_arb_pkg;

  localparam int ADDR_W_DEFAULT = 24;
  localparam int DATA_W_DEFAULT = 32;

  localparam int PORT_IF = 0;
  localparam int PORT_D  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/flash_arb_rr_arb2.sv
// Two-way round-robin picker: combinational one-hot grant, last winner registered on advance.
module flash_rr_arb2
  import flash_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 = data port won last, so fetch wins the first tie after reset
  logic last_grant;

  always_comb begin
    grant = req;
    if (req[PORT_IF] && req[PORT_D]) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (advance && (|grant)) begin
      last_grant <= grant[PORT_D];
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Round-robin sharing of one SPI flash controller between fetch and data ports.
// Command out one cycle after grant; ack one cycle after controller done; holds requests while flash_ready=0.
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = 2097152
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              flash_en,
  output logic              flash_write,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_data_in,
  input  logic [DATA_W-1:0] flash_data_out,
  input  logic              flash_ready,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             port_d;
  logic [1:0]       grant;
  logic             advance;
  logic             done;
  logic             expire;

  // Requests seen during an ack pulse are ignored; arbitration waits for a clean IDLE cycle.
  assign advance = (state == IDLE) && flash_ready && (if_req || d_req) && !(if_ack || d_ack);
  assign done    = (state == WAIT) && flash_ready;
  assign expire  = ((state == ISSUE) || (state == WAIT)) && !done && (cnt == CNT_LAST);

  flash_rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({d_req, if_req}),
    .advance (advance),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (advance) state_next = ISSUE;
      end
      ISSUE: begin
        if (expire)            state_next = IDLE;
        else if (!flash_ready) state_next = WAIT;
      end
      WAIT: begin
        if (expire)    state_next = IDLE;
        else if (done) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_ack        <= 1'b0;
      d_ack         <= 1'b0;
      err           <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
      flash_en      <= 1'b0;
      flash_write   <= 1'b0;
      flash_addr    <= '0;
      flash_data_in <= '0;
      busy          <= 1'b0;
      cnt           <= '0;
      port_d        <= 1'b0;
    end else begin
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      err      <= 1'b0;
      flash_en <= (state_next == ISSUE);
      busy     <= (state_next != IDLE);

      if (advance) begin
        port_d        <= grant[PORT_D];
        flash_addr    <= grant[PORT_IF] ? if_addr : d_addr;
        flash_write   <= grant[PORT_D] & d_write;
        flash_data_in <= grant[PORT_IF] ? '0 : d_wdata;
        cnt           <= '0;
      end else if ((state == ISSUE) || (state == WAIT)) begin
        cnt <= cnt + 1'b1;
      end

      if (done) begin
        if (port_d) begin
          d_ack   <= 1'b1;
          d_rdata <= flash_write ? '0 : flash_data_out;
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= flash_data_out;
        end
      end else if (expire) begin
        err <= 1'b1;
        if (port_d) begin
          d_ack   <= 1'b1;
          d_rdata <= '0;
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= '0;
        end
      end
    end
  end

endmodule
